// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the cpu register file
package cpu_pkg;

  // Default register width and reset values
  localparam int            DATA_W_DEF = 8;
  localparam int            NUM_REGS_DEF = 5;
  localparam logic [7:0]    SP_RST_DEF = 8'hFD;
  localparam logic [7:0]    P_RST_DEF  = 8'h24;

  // Register index; 3 bits so that out-of-range ids (5..7) are representable
  typedef logic [2:0] reg_id_t;

  localparam reg_id_t REG_A  = 3'd0;
  localparam reg_id_t REG_X  = 3'd1;
  localparam reg_id_t REG_Y  = 3'd2;
  localparam reg_id_t REG_SP = 3'd3;
  localparam reg_id_t REG_P  = 3'd4;

  // Hardware stack-pointer adjust
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_INC  = 2'd1,
    SP_DEC  = 2'd2
  } sp_op_t;

  // Status register bit positions
  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

endpackage

// File: rtl/cpu_regfile_if.sv
// rtl/cpu_regfile_if.sv - execute-stage to register file bus
interface cpu_regfile_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_RD = 2
);

  reg_id_t [NUM_RD-1:0]             rd_addr_i;
  logic    [NUM_RD-1:0][DATA_W-1:0] rd_data_o;
  logic                             wr_en_i;
  reg_id_t                          wr_addr_i;
  logic    [DATA_W-1:0]             wr_data_i;
  sp_op_t                           sp_op_i;
  logic    [DATA_W-1:0]             flag_we_i;
  logic    [DATA_W-1:0]             flag_i;
  logic    [DATA_W-1:0]             sp_o;
  logic    [DATA_W-1:0]             p_o;

  // Execute side: issues reads, writes, SP adjusts and flag updates
  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, sp_op_i, flag_we_i, flag_i,
    input  rd_data_o, sp_o, p_o
  );

  // Register file side
  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, sp_op_i, flag_we_i, flag_i,
    output rd_data_o, sp_o, p_o
  );

endinterface

// File: rtl/cpu_regfile_rdport.sv
// rtl/cpu_regfile_rdport.sv - one combinational read port with range check and bypass
module cpu_regfile_rdport
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5,
  parameter int BYPASS   = 1
) (
  input  reg_id_t                            rd_addr_i,
  input  logic    [NUM_REGS-1:0][DATA_W-1:0] regs_i,
  input  logic                               wr_en_i,
  input  reg_id_t                            wr_addr_i,
  input  logic    [DATA_W-1:0]               wr_data_i,
  output logic    [DATA_W-1:0]               rd_data_o
);

  logic in_range;
  logic hit;

  assign in_range = 32'(rd_addr_i) < NUM_REGS;
  // Only full-register writes are forwarded; SP and flag results are not
  assign hit      = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i);

  // Select forwarded write data, stored value, or zero for unmapped ids
  always_comb begin
    rd_data_o = '0;
    if (in_range) begin
      if (hit) begin
        rd_data_o = wr_data_i;
        if (rd_addr_i == REG_P) rd_data_o[P_U] = 1'b1;
      end else begin
        rd_data_o = regs_i[rd_addr_i];
      end
    end
  end

endmodule

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - architectural register file with SP adjust and flag updates
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                NUM_REGS = 5,
  parameter int                NUM_RD   = 2,
  parameter int                BYPASS   = 1,
  parameter logic [DATA_W-1:0] SP_RST   = 8'hFD,
  parameter logic [DATA_W-1:0] P_RST    = 8'h24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  cpu_regfile_if.slave bus
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0]               regs_q [NUM_REGS];
  logic [DATA_W-1:0]               regs_d [NUM_REGS];
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_flat;
  logic [DATA_W-1:0]               rd_data [NUM_RD];

  // Next state per register: full write beats SP adjust / flag merge; P bit 5 pinned high
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (bus.wr_en_i && (bus.wr_addr_i == reg_id_t'(i))) begin
        regs_d[i] = bus.wr_data_i;
      end else if (i == int'(REG_SP)) begin
        case (bus.sp_op_i)
          SP_INC:  regs_d[i] = regs_q[i] + ONE;
          SP_DEC:  regs_d[i] = regs_q[i] - ONE;
          default: regs_d[i] = regs_q[i];
        endcase
      end else if (i == int'(REG_P)) begin
        regs_d[i] = (regs_q[i] & ~bus.flag_we_i) | (bus.flag_i & bus.flag_we_i);
      end
      if (i == int'(REG_P)) regs_d[i][P_U] = 1'b1;
    end
  end

  // Register state; reset overrides every update in the same cycle
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst_i) begin
        if (i == int'(REG_SP))     regs_q[i] <= SP_RST;
        else if (i == int'(REG_P)) regs_q[i] <= P_RST | (ONE << P_U);
        else                       regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Packed view of storage for the read ports
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i] = regs_q[i];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    cpu_regfile_rdport #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .BYPASS   (BYPASS)
    ) u_rdport (
      .rd_addr_i (bus.rd_addr_i[k]),
      .regs_i    (regs_flat),
      .wr_en_i   (bus.wr_en_i),
      .wr_addr_i (bus.wr_addr_i),
      .wr_data_i (bus.wr_data_i),
      .rd_data_o (rd_data[k])
    );
    assign bus.rd_data_o[k] = rd_data[k];
  end

  assign bus.sp_o = regs_q[REG_SP];
  assign bus.p_o  = regs_q[REG_P];

endmodule

// File: doc/cpu_regfile.md
# cpu_regfile

Parametrised architectural register file for the 6502-class core: A, X, Y, SP and P held in one array with multiple combinational read ports, one synchronous write port, hardware stack-pointer increment/decrement and per-flag status updates. Sits between decode/execute and the ALU; the execute stage drives writes, SP adjusts and flag updates in the same cycle.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- NUM_REGS, 5, number of architectural registers (index by reg_id_t)
- NUM_RD, 2, number of independent read ports
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports
- SP_RST, 8'hFD, stack pointer reset value
- P_RST, 8'h24, status register reset value

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous and active-high
- rd_addr_i  in  NUM_RD x reg_id_t  read address per port
- rd_data_o  out  NUM_RD x DATA_W  read data per port
- wr_en_i  in  1  full-register write enable
- wr_addr_i  in  reg_id_t  write address
- wr_data_i  in  DATA_W  write data
- sp_op_i  in  sp_op_t  SP_NONE / SP_INC / SP_DEC
- flag_we_i  in  DATA_W  per-bit write mask for P
- flag_i  in  DATA_W  new flag values, applied where flag_we_i bit is 1
- sp_o  out  DATA_W  current SP (registered value)
- p_o  out  DATA_W  current P (registered value, bit 5 forced 1)

## Operation
- Reset (rst_i=1 at a rising edge): A=X=Y=0, SP=SP_RST, P=P_RST; overrides every write, sp_op and flag update in that cycle. During reset cycles outputs reflect register contents (reset values after the first edge).
- Full write: wr_en_i=1 and wr_addr_i < NUM_REGS writes wr_data_i at next edge. wr_addr_i >= NUM_REGS: write dropped.
- SP op: SP_INC adds 1, SP_DEC subtracts 1, modulo 2^DATA_W (FF+1 -> 00, 00-1 -> FF).
- Flag update: P_next = (P & ~flag_we_i) | (flag_i & flag_we_i).
- P bit 5 always stored and read as 1 regardless of write data.
- Priority per register, highest first: reset, full write to that register, SP op / flag update. Full write to SP with SP_INC in the same cycle: SP = wr_data_i. Full write to P with flag_we_i≠0: P = wr_data_i (bit 5 forced).
- Full write to A/X/Y concurrent with sp_op and flag update: all three take effect.
- Read: rd_addr_i >= NUM_REGS returns 0. Reading SP/P returns stored values.
- BYPASS=1: if wr_en_i=1 and wr_addr_i matches a read port address, that port returns wr_data_i (bit 5 forced when P). SP-op and flag results are NOT forwarded. BYPASS=0: reads always return stored value.

## Timing
- Read ports combinational, zero latency from rd_addr_i.
- Writes, SP ops and flag updates visible on sp_o/p_o/rd_data_o one cycle after the edge on which they are sampled.
- No handshake; every request is accepted every cycle; back-to-back SP_DEC for N cycles decrements SP by N.

## Structure
- Shared package cpu_pkg: reg_id_t (REG_A=0, REG_X=1, REG_Y=2, REG_SP=3, REG_P=4), sp_op_t, P bit positions (C=0, Z=1, I=2, D=3, B=4, U=5, V=6, N=7), default reset constants.
- Sub-module cpu_regfile_rdport: one read port (address decode, range check, bypass mux), instantiated NUM_RD times via generate.
- Register update logic and priority stays in cpu_regfile.

## Test plan
- Reset: assert rst_i 2 cycles -> A=X=Y=00, sp_o=FD, p_o=24; write of A=55 in a reset cycle is dropped.
- Write/read: write A=3C, X=7F; next cycle port0 reads A=3C, port1 reads X=7F; same-cycle read of X while writing X=11 returns 11 (BYPASS=1) or 7F (BYPASS=0).
- SP wrap: SP=01, three SP_DEC cycles -> 00, FF, FE; SP=FF with SP_INC -> 00; write SP=40 with SP_INC same cycle -> 40.
- Flags: P=24, flag_we_i=83, flag_i=FF -> P=A7; flag_we_i=20, flag_i=00 -> bit 5 stays 1; write P=00 -> p_o=20.
- Out of range: write addr 6 data AA -> no register changes; read addr 7 -> 00.
- Concurrency: write Y=09, SP_DEC and flag_we_i=02 flag_i=02 in one cycle -> Y=09, SP decremented, Z set.
